// File: rtl/display_scan_mux.sv
// Time-multiplexed hex scanner that feeds a shared 7-segment decoder and updates its value frame-synchronously.
// Optional build macro LEADING_ZERO_BLANK_EN suppresses leading zero digits.
module display_scan_mux #(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 50000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load,
  input  logic [4*DIGITS-1:0]       value,
  output logic [3:0]                num,
  output logic [DIGITS-1:0]         anode,
  output logic [$clog2(DIGITS)-1:0] digit_idx,
  output logic                      frame_done,
  output logic                      blank
);

  localparam int IW = $clog2(DIGITS);
  localparam int PW = $clog2(SCAN_DIV);

  logic [PW-1:0]       presc;
  logic [IW-1:0]       idx;
  logic [4*DIGITS-1:0] disp;
  logic [4*DIGITS-1:0] shadow;
  logic                pending;
  logic                tc;
  logic                last;
  logic                fb;

  assign tc   = (presc == PW'(SCAN_DIV - 1));
  assign last = (idx == IW'(DIGITS - 1));
  assign fb   = tc && last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc      <= '0;
      idx        <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= fb;
      if (tc) begin
        presc <= '0;
        idx   <= last ? '0 : idx + IW'(1);
      end else begin
        presc <= presc + PW'(1);
      end
    end
  end

  // A load coinciding with the frame boundary bypasses the shadow so the newest value wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp    <= '0;
      shadow  <= '0;
      pending <= 1'b0;
    end else if (load && fb) begin
      disp    <= value;
      pending <= 1'b0;
    end else if (load) begin
      shadow  <= value;
      pending <= 1'b1;
    end else if (fb && pending) begin
      disp    <= shadow;
      pending <= 1'b0;
    end
  end

  logic [3:0]        nib;
  logic [DIGITS-1:0] onehot;
  logic              blank_int;

`ifdef LEADING_ZERO_BLANK_EN
  // upzero[i] is set when nibbles i..DIGITS-1 are all zero.
  logic [DIGITS-1:0] upzero;
  logic              lz;

  always_comb begin
    upzero = '0;
    upzero[DIGITS-1] = (disp[4*(DIGITS-1) +: 4] == 4'h0);
    for (int i = DIGITS - 2; i >= 0; i--) begin
      upzero[i] = upzero[i+1] && (disp[4*i +: 4] == 4'h0);
    end
  end

  always_comb begin
    nib = 4'h0;
    lz  = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IW'(i)) begin
        nib = disp[4*i +: 4];
        lz  = upzero[i];
      end
    end
  end

  assign blank_int = (idx != '0) && lz;
`else
  always_comb begin
    nib = 4'h0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IW'(i)) begin
        nib = disp[4*i +: 4];
      end
    end
  end

  assign blank_int = 1'b0;
`endif

  assign onehot    = DIGITS'(1) << idx;
  assign num       = blank_int ? 4'h0 : nib;
  assign anode     = blank_int ? '1 : ~onehot;
  assign digit_idx = idx;
  assign blank     = blank_int;

endmodule

// File: tb/tb_display_scan_mux.sv
// Directed bench for display_scan_mux with DIGITS=4, SCAN_DIV=4 (16-cycle frames).
// Blank expectations follow LEADING_ZERO_BLANK_EN when that macro is defined.
module tb_display_scan_mux;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] value = 16'h0;
  logic [3:0]  num;
  logic [3:0]  anode;
  logic [1:0]  digit_idx;
  logic        frame_done;
  logic        blank;

  int vecCount  = 0;
  int missCount = 0;

  display_scan_mux #(.DIGITS(4), .SCAN_DIV(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .value      (value),
    .num        (num),
    .anode      (anode),
    .digit_idx  (digit_idx),
    .frame_done (frame_done),
    .blank      (blank)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vecCount++;
    if (obs !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Walks one whole frame from offset 0, checking every cycle; loads fire at offsets at1/at2 (-1 = none).
  task automatic applyStimulus(input logic [15:0] shown, input bit fdFirst,
                               input int at1, input logic [15:0] v1,
                               input int at2, input logic [15:0] v2);
    int         d;
    logic [3:0] nibExp;
    logic [3:0] anExp;
    bit         blankExp;
    for (int j = 0; j < 16; j++) begin
      d = j / 4;
      blankExp = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
      blankExp = (d > 0) && ((shown >> (4 * d)) == 16'h0);
`endif
      nibExp = blankExp ? 4'h0 : 4'((shown >> (4 * d)) & 16'hF);
      anExp  = blankExp ? 4'hF : ~(4'b0001 << d);
      checkOutput("num", 16'(num), 16'(nibExp));
      checkOutput("anode", 16'(anode), 16'(anExp));
      checkOutput("digit_idx", 16'(digit_idx), 16'(d));
      checkOutput("blank", 16'(blank), 16'(blankExp));
      checkOutput("frame_done", 16'(frame_done), 16'((j == 0) && fdFirst));
      if (j == at1) begin
        load = 1'b1;
        value = v1;
      end else if (j == at2) begin
        load = 1'b1;
        value = v2;
      end
      tick();
      load = 1'b0;
    end
  endtask

  initial begin
    tick();
    tick();
    checkOutput("rst_anode", 16'(anode), 16'h000E);
    checkOutput("rst_num", 16'(num), 16'h0);
    checkOutput("rst_idx", 16'(digit_idx), 16'h0);
    checkOutput("rst_fd", 16'(frame_done), 16'h0);
    checkOutput("rst_blank", 16'(blank), 16'h0);
    rst = 1'b0;

    $display("[TB] free-running scan");
    applyStimulus(16'h0000, 1'b0, -1, 16'h0, -1, 16'h0);
    applyStimulus(16'h0000, 1'b1, -1, 16'h0, -1, 16'h0);

    $display("[TB] mid-frame load");
    applyStimulus(16'h0000, 1'b1, 5, 16'h1A2F, -1, 16'h0);
    applyStimulus(16'h1A2F, 1'b1, -1, 16'h0, -1, 16'h0);

    $display("[TB] load on frame boundary");
    applyStimulus(16'h1A2F, 1'b1, 15, 16'h00C3, -1, 16'h0);
    applyStimulus(16'h00C3, 1'b1, -1, 16'h0, -1, 16'h0);
    applyStimulus(16'h00C3, 1'b1, -1, 16'h0, -1, 16'h0);

    $display("[TB] last load in a frame wins");
    applyStimulus(16'h00C3, 1'b1, 2, 16'h1111, 9, 16'h2222);
    applyStimulus(16'h2222, 1'b1, -1, 16'h0, -1, 16'h0);

    $display("[TB] reset mid-frame");
    load = 1'b1;
    value = 16'h5555;
    tick();
    load = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    checkOutput("pre_rst_num", 16'(num), 16'h2);
    rst = 1'b1;
    #1;
    checkOutput("async_anode", 16'(anode), 16'h000E);
    checkOutput("async_num", 16'(num), 16'h0);
    checkOutput("async_idx", 16'(digit_idx), 16'h0);
    tick();
    checkOutput("held_anode", 16'(anode), 16'h000E);
    checkOutput("held_fd", 16'(frame_done), 16'h0);
    rst = 1'b0;
    applyStimulus(16'h0000, 1'b0, -1, 16'h0, -1, 16'h0);

    $display("[TB] leading-zero patterns");
    applyStimulus(16'h0000, 1'b1, 0, 16'h0030, -1, 16'h0);
    applyStimulus(16'h0030, 1'b1, 7, 16'h0000, -1, 16'h0);
    applyStimulus(16'h0000, 1'b1, -1, 16'h0, -1, 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
